// File: rtl/sub_serial_if.sv
// sub_serial_if: start/operand/result bundle for sub_serial.
// Carries the borrow-in bit bi when SUB_SERIAL_BIN_EN is defined.
interface sub_serial_if #(
    parameter int WIDTH = 32
);
    logic             start, busy, done, bo, ov;
    logic [WIDTH-1:0] a, b, d;
`ifdef SUB_SERIAL_BIN_EN
    logic             bi;
    modport master(output start, a, b, bi, input busy, done, d, bo, ov);
    modport slave(input start, a, b, bi, output busy, done, d, bo, ov);
`else
    modport master(output start, a, b, input busy, done, d, bo, ov);
    modport slave(input start, a, b, output busy, done, d, bo, ov);
`endif
endinterface

// File: rtl/sub_serial.sv
// sub_serial: bit-serial two's-complement subtractor d = a - b, LSB first, start/done handshake.
// Define SUB_SERIAL_BIN_EN to add the borrow-in port bi (d = a - b - bi).
module sub_serial #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        clrn,
    sub_serial_if.slave s
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_sa, r_sb, r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_amsb, r_bmsb, r_busy, r_done, r_bo, r_ov;
    logic             w_dbit, w_br_next, w_bin;
    assign w_dbit    = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next = (~r_sa[0] & r_sb[0]) | (~r_sa[0] & r_br) | (r_sb[0] & r_br);
`ifdef SUB_SERIAL_BIN_EN
    assign w_bin = s.bi;
`else
    assign w_bin = 1'b0;
`endif
    assign s.busy = r_busy;
    assign s.done = r_done;
    assign s.d    = r_d;
    assign s.bo   = r_bo;
    assign s.ov   = r_ov;
    // SA doubles as the working result register: difference bits enter at the MSB
    // as minuend bits leave at the LSB, so d stays untouched until completion.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bo    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (s.start) begin
                    r_sa    <= s.a;
                    r_sb    <= s.b;
                    r_br    <= w_bin;
                    r_cnt   <= '0;
                    r_amsb  <= s.a[WIDTH-1];
                    r_bmsb  <= s.b[WIDTH-1];
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_sa  <= {w_dbit, r_sa[WIDTH-1:1]};
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_d     <= {w_dbit, r_sa[WIDTH-1:1]};
                        r_bo    <= w_br_next;
                        r_ov    <= (r_amsb != r_bmsb) & (w_dbit != r_amsb);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: randomized and directed checks of sub_serial against an arithmetic reference model.
module tb_sub_serial;
    localparam int W = 8;
    logic         clk = 1'b0, clrn = 1'b0, bi_v = 1'b0;
    int           n_vec = 0, n_err = 0;
    logic [W-1:0] prev_d = '0;
    logic         prev_bo = 1'b0, prev_ov = 1'b0;

    sub_serial_if #(.WIDTH(W)) bus();
    sub_serial #(.WIDTH(W)) dut(.clk(clk), .clrn(clrn), .s(bus));
`ifdef SUB_SERIAL_BIN_EN
    assign bus.bi = bi_v;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {bo, ov, d} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int u   = int'(x) - int'(y) - int'(c);
        int sdf = int'($signed(x)) - int'($signed(y)) - int'(c);
        logic [W-1:0] dd = u[W-1:0];
        return {u < 0, (sdf < -(2 ** (W - 1))) || (sdf > 2 ** (W - 1) - 1), dd};
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit toggle, input string tag);
        logic [W+1:0] e = model(x, y, c);
        int n = 0, nb = 1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y; bi_v = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy_acc"}, 32'(bus.busy), 1);
        while (!bus.done && n < 20) begin
            if (toggle) begin
                bus.a = W'($urandom); bus.b = W'($urandom);
                bus.start = 1'($urandom); bi_v = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (bus.busy) nb++;
            if (n == 4) check({tag, "_hold"}, 32'({bus.bo, bus.ov, bus.d}), 32'({prev_bo, prev_ov, prev_d}));
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(n), W);
        check({tag, "_result"}, 32'({bus.bo, bus.ov, bus.d}), 32'(e));
        {prev_bo, prev_ov, prev_d} = e;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 0);
        check({tag, "_busy_cycles"}, 32'(nb + (bus.busy ? 1 : 0)), W + 1);
    endtask

    task automatic abort_test();
        int nd = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h21; bi_v = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_res", 32'({bus.bo, bus.ov, bus.d}), 0);
        @(posedge clk); #2 clrn = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) nd++;
        end
        check("abort_quiet", 32'(nd), 0);
        {prev_bo, prev_ov, prev_d} = '0;
    endtask

    task automatic b2b_test();
        logic [W-1:0] ca, cb;
        logic         cc;
        logic [W+1:0] e;
        int g, n;
        @(negedge clk);
        ca = W'($urandom); cb = W'($urandom);
`ifdef SUB_SERIAL_BIN_EN
        cc = 1'($urandom);
`else
        cc = 1'b0;
`endif
        bus.start = 1'b1; bus.a = ca; bus.b = cb; bi_v = cc;
        for (int k = 0; k < 5; k++) begin
            g = 0;
            do begin
                @(posedge clk); #1;
                g++;
            end while (!bus.busy && g < 20);
            check("b2b_gap", 32'(g), k == 0 ? 1 : 2);
            e = model(ca, cb, cc);
            ca = W'($urandom); cb = W'($urandom);
            bus.a = ca; bus.b = cb;
`ifdef SUB_SERIAL_BIN_EN
            cc = 1'($urandom);
            bi_v = cc;
`endif
            n = 0;
            while (!bus.done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("b2b_latency", 32'(n), W);
            check("b2b_result", 32'({bus.bo, bus.ov, bus.d}), 32'(e));
            {prev_bo, prev_ov, prev_d} = e;
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("b2b_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        logic c;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_res", 32'({bus.bo, bus.ov, bus.d}), 0);
        @(negedge clk) clrn = 1'b1;
        run_op(8'h05, 8'h03, 1'b0, 1'b0, "d05_03");
        run_op(8'h03, 8'h05, 1'b0, 1'b0, "d03_05");
        run_op(8'h80, 8'h01, 1'b0, 1'b0, "d80_01");
        run_op(8'h10, 8'h01, 1'b0, 1'b1, "ignore");
        abort_test();
        run_op(8'h09, 8'h09, 1'b0, 1'b0, "d09_09");
        b2b_test();
`ifdef SUB_SERIAL_BIN_EN
        run_op(8'h00, 8'h00, 1'b1, 1'b0, "bin");
`endif
        repeat (15) begin
`ifdef SUB_SERIAL_BIN_EN
            c = 1'($urandom);
`else
            c = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), c, 1'($urandom), "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
